// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// lcd_pkg : shared state encoding, init command table and timing defaults
// Rev 1.0 : initial release
// ============================================================================
package lcd_pkg;

    localparam int unsigned CNT_W = 20;

    localparam int unsigned DEF_T_POWERUP = 750000;
    localparam int unsigned DEF_T_SETUP   = 2;
    localparam int unsigned DEF_T_PULSE   = 12;
    localparam int unsigned DEF_T_HOLD    = 2;
    localparam int unsigned DEF_T_EXEC    = 2000;
    localparam int unsigned DEF_T_CLEAR   = 82000;

    localparam logic [1:0] INIT_LAST = 2'd3;

    typedef enum logic [2:0] {
        ST_POWERUP = 3'd0,
        ST_SETUP   = 3'd1,
        ST_PULSE   = 3'd2,
        ST_HOLD    = 3'd3,
        ST_WAIT    = 3'd4,
        ST_IDLE    = 3'd5
    } lcd_state_t;

    // Function set 8-bit/2-line, display on, clear, entry mode increment.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h01;
            default: init_cmd = 8'h06;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] clamp_cycles(input int unsigned cycles);
        clamp_cycles = (cycles == 0) ? CNT_W'(1) : CNT_W'(cycles);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_delay_counter.sv
`default_nettype none
// ============================================================================
// lcd_delay_counter : reloadable downcounter timing every sequencer state
// Rev 1.0 : initial release
// ============================================================================
module lcd_delay_counter
    import lcd_pkg::*;
#(
    parameter logic [CNT_W-1:0] RESET_VALUE = CNT_W'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RESET_VALUE;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    // A load of N makes the owning state last exactly N cycles.
    assign done_o = (count_q <= CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/lcd_sequencer.sv
`default_nettype none
// ============================================================================
// lcd_sequencer : HD44780-style write-only LCD init and byte sequencer
// Rev 1.0 : initial release
// ============================================================================
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned T_POWERUP = DEF_T_POWERUP,
    parameter int unsigned T_SETUP   = DEF_T_SETUP,
    parameter int unsigned T_PULSE   = DEF_T_PULSE,
    parameter int unsigned T_HOLD    = DEF_T_HOLD,
    parameter int unsigned T_EXEC    = DEF_T_EXEC,
    parameter int unsigned T_CLEAR   = DEF_T_CLEAR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reqValid,
    input  logic       reqIsData,
    input  logic [7:0] reqByte,
    output logic       reqReady,
    output logic       initDone,
    output logic       LCD_ON,
    output logic       LCD_RS,
    output logic       LCD_EN,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA
);

    localparam logic [CNT_W-1:0] POWERUP_CYC = clamp_cycles(T_POWERUP);
    localparam logic [CNT_W-1:0] SETUP_CYC   = clamp_cycles(T_SETUP);
    localparam logic [CNT_W-1:0] PULSE_CYC   = clamp_cycles(T_PULSE);
    localparam logic [CNT_W-1:0] HOLD_CYC    = clamp_cycles(T_HOLD);
    localparam logic [CNT_W-1:0] EXEC_CYC    = clamp_cycles(T_EXEC);
    localparam logic [CNT_W-1:0] CLEAR_CYC   = clamp_cycles(T_CLEAR);

    lcd_state_t       state_q;
    logic [1:0]       init_idx_q;
    logic             init_done_q;
    logic             ready_q;
    logic             on_q;
    logic             en_q;
    logic             rs_q;
    logic [7:0]       data_q;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_done;
    logic             is_clear;

    assign is_clear = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));

    // Reload the counter with the duration of whichever state comes next.
    always_comb begin
        cnt_load  = 1'b0;
        cnt_value = SETUP_CYC;
        case (state_q)
            ST_POWERUP, ST_WAIT: cnt_load = cnt_done;
            ST_SETUP: begin
                cnt_load  = cnt_done;
                cnt_value = PULSE_CYC;
            end
            ST_PULSE: begin
                cnt_load  = cnt_done;
                cnt_value = HOLD_CYC;
            end
            ST_HOLD: begin
                cnt_load  = cnt_done;
                cnt_value = is_clear ? CLEAR_CYC : EXEC_CYC;
            end
            ST_IDLE: cnt_load = reqValid;
            default: cnt_load = 1'b0;
        endcase
    end

    lcd_delay_counter #(
        .RESET_VALUE(POWERUP_CYC)
    ) u_delay (
        .clk    (clk),
        .reset  (reset),
        .load_i (cnt_load),
        .value_i(cnt_value),
        .done_o (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_POWERUP;
            init_idx_q  <= 2'd0;
            init_done_q <= 1'b0;
            ready_q     <= 1'b0;
            on_q        <= 1'b1;
            en_q        <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
        end else begin
            case (state_q)
                ST_POWERUP: begin
                    if (cnt_done) begin
                        state_q    <= ST_SETUP;
                        init_idx_q <= 2'd0;
                        rs_q       <= 1'b0;
                        data_q     <= init_cmd(2'd0);
                    end
                end
                ST_SETUP: begin
                    if (cnt_done) begin
                        state_q <= ST_PULSE;
                        en_q    <= 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt_done) begin
                        state_q <= ST_HOLD;
                        en_q    <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (cnt_done) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_done) begin
                        if (!init_done_q && (init_idx_q != INIT_LAST)) begin
                            state_q    <= ST_SETUP;
                            init_idx_q <= init_idx_q + 2'd1;
                            rs_q       <= 1'b0;
                            data_q     <= init_cmd(init_idx_q + 2'd1);
                        end else begin
                            state_q     <= ST_IDLE;
                            ready_q     <= 1'b1;
                            init_done_q <= 1'b1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (reqValid) begin
                        state_q <= ST_SETUP;
                        ready_q <= 1'b0;
                        rs_q    <= reqIsData;
                        data_q  <= reqByte;
                    end
                end
                default: begin
                    state_q <= ST_POWERUP;
                    ready_q <= 1'b0;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

    assign reqReady = ready_q;
    assign initDone = init_done_q;
    assign LCD_ON   = on_q;
    assign LCD_EN   = en_q;
    assign LCD_RS   = rs_q;
    assign LCD_RW   = 1'b0;
    assign LCD_DATA = data_q;

endmodule
`default_nettype wire

// File: doc/lcd_sequencer.md
LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- T_POWERUP, 750000, cycles of idle after reset before the first init command (15 ms at 50 MHz).
- T_SETUP, 2, cycles RS/DATA stable before EN rises.
- T_PULSE, 12, cycles EN held high.
- T_HOLD, 2, cycles RS/DATA held after EN falls.
- T_EXEC, 2000, execution wait after a normal byte (40 us).
- T_CLEAR, 82000, execution wait after command 0x01 or 0x02 (1.64 ms).
REQ-002 Clock and reset are decided: one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  rising-edge system clock.
- reset  in  1  synchronous, active-high reset.
- reqValid  in  1  requester offers a byte.
- reqIsData  in  1  1 = character (RS=1), 0 = command (RS=0).
- reqByte  in  8  byte to write.
- reqReady  out  1  sequencer accepts the offered byte this cycle.
- initDone  out  1  init sequence complete; stays high until reset.
- LCD_ON  out  1  panel power.
- LCD_RS  out  1  register select.
- LCD_EN  out  1  enable strobe.
- LCD_RW  out  1  read/write; constant 0 (write-only).
- LCD_DATA  out  8  data bus.

Function
REQ-004 States SHALL be POWERUP, SETUP, PULSE, HOLD, WAIT, IDLE.
REQ-005 POWERUP SHALL last T_POWERUP cycles, then load init command 0 and go to SETUP.
REQ-006 The init sequence SHALL be 0x38, 0x0C, 0x01, 0x06, all with RS=0, each running SETUP->PULSE->HOLD->WAIT.
REQ-007 SETUP, PULSE, HOLD SHALL last exactly T_SETUP, T_PULSE, T_HOLD cycles; a parameter value of 0 SHALL behave as 1.
REQ-008 LCD_EN SHALL be 1 only in PULSE.
REQ-009 LCD_RS and LCD_DATA SHALL hold the latched byte from SETUP through HOLD.
REQ-010 WAIT SHALL last T_CLEAR cycles if the latched byte is a command equal to 0x01 or 0x02, otherwise T_EXEC cycles.
REQ-011 After WAIT of init command 3, initDone SHALL rise and the sequencer SHALL enter IDLE.
REQ-012 After WAIT of any user byte, the sequencer SHALL enter IDLE.
REQ-013 reqReady SHALL equal (state==IDLE).
REQ-014 A transfer occurs when reqValid&&reqReady; reqIsData/reqByte SHALL be latched that cycle and SETUP SHALL begin on the next cycle.
REQ-015 reqValid while not ready SHALL be ignored without being queued; the requester SHALL hold it.
REQ-016 In IDLE, LCD_EN SHALL be 0 and LCD_RS/LCD_DATA SHALL keep the last value.
REQ-017 Delay counters SHALL be 20 bits wide, downcounting, reloaded on each state entry.
REQ-018 The latency from accept to EN rise SHALL be 1+T_SETUP cycles; from accept to reqReady high again, 1+T_SETUP+T_PULSE+T_HOLD+wait cycles.

Reset
REQ-019 On reset: state=POWERUP, LCD_ON=1, LCD_EN=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00, reqReady=0, initDone=0, init index=0, counters loaded with T_POWERUP.
REQ-020 Reset asserted mid-PULSE SHALL drive LCD_EN low on the next edge and restart the full init sequence.

Structure
REQ-021 Init command table, state encoding and default timing constants SHALL live in shared package lcd_pkg.
REQ-022 One sub-module, lcd_delay_counter (load/value/done), is natural and SHALL be used for all timed states.
REQ-023 Outputs SHALL be registered; no combinational path from reqValid to any LCD_* output.

Verification (T_POWERUP=10, T_SETUP=1, T_PULSE=2, T_HOLD=1, T_EXEC=4, T_CLEAR=8)
REQ-024 Reset released -> EN pulses with DATA 0x38, 0x0C, 0x01, 0x06 (RS=0); gap after 0x01 is 8 wait cycles; initDone rises; reqReady=1.
REQ-025 After init, offer data 0x41 -> reqReady drops next cycle, RS=1, DATA=0x41, EN high exactly 2 cycles starting 2 cycles after accept, reqReady back 9 cycles after accept.
REQ-026 reqValid held continuously with 0x41 then 0x42 -> exactly one EN pulse per byte; no byte lost or duplicated.
REQ-027 User command 0x01 -> WAIT of 8 cycles; command 0x80 -> WAIT of 4 cycles.
REQ-028 reset asserted during PULSE of the second init command -> EN=0 next cycle, initDone=0, POWERUP restarts, 0x38 re-sent first.
REQ-029 reqValid asserted during POWERUP/init -> ignored; LCD_RW=0 and LCD_ON=1 throughout.
